inst_issue_buffer: RTL and testbench

//  Parametrised in-order instruction buffer between the decoder and issue logic. It accepts up to IN_W

---
 rtl/inst_issue_buffer_pkg.sv | 34 +++
 rtl/ibuf_mem.sv | 41 ++++
 rtl/inst_issue_buffer.sv | 130 +++++++++++++
 tb/tb_inst_issue_buffer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_issue_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : inst_issue_buffer_pkg
//  Purpose  : Shared constants and helpers for the instruction issue buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package inst_issue_buffer_pkg;

  // Default payload width of one decoded packet.
  localparam int IBUF_DATA_W = 64;

  // Widest lane vector lead_ones() accepts, and the width of its result.
  localparam int LO_MAX = 16;
  localparam int LO_CW  = $clog2(LO_MAX + 1);

  // Number of consecutive ones in v starting at bit 0, looking at the low n
  // bits only. Callers zero-extend their N-bit vector to LO_MAX bits.
  function automatic logic [LO_CW-1:0] lead_ones(input logic [LO_MAX-1:0] v,
                                                 input int n);
    logic [LO_CW-1:0] cnt;
    logic             run;
    cnt = '0;
    run = 1'b1;
    for (int i = 0; i < LO_MAX; i++) begin
      if (i < n && run) begin
        if (v[i]) cnt = cnt + 1'b1;
        else      run = 1'b0;
      end
    end
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ibuf_mem.sv
`default_nettype none
// ============================================================================
//  Module   : ibuf_mem
//  Purpose  : DEPTH x DATA_WIDTH register file, IN_W write ports and OUT_W
//             asynchronous read ports addressed by pre-rotated addresses.
//  Revision : 1.0 - initial release
// ============================================================================
module ibuf_mem #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 64,
  parameter int IN_W       = 2,
  parameter int OUT_W      = 2,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic [IN_W-1:0]             i_we,
  input  logic [IN_W*PTR_W-1:0]       i_waddr,
  input  logic [IN_W*DATA_WIDTH-1:0]  i_wdata,
  input  logic [OUT_W*PTR_W-1:0]      i_raddr,
  output logic [OUT_W*DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Storage write; lanes always target distinct slots, so order is irrelevant.
  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < IN_W; k++) begin
      if (i_we[k]) r_mem[i_waddr[k*PTR_W +: PTR_W]] <= i_wdata[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  genvar g;
  generate
    for (g = 0; g < OUT_W; g++) begin : g_rd
      assign o_rdata[g*DATA_WIDTH +: DATA_WIDTH] = r_mem[i_raddr[g*PTR_W +: PTR_W]];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/inst_issue_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : inst_issue_buffer
//  Purpose  : In-order instruction buffer between decode and issue. Accepts
//             up to IN_W packets per cycle, exposes the oldest OUT_W as a
//             registered issue window and retires any issued in-order prefix.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_issue_buffer
  import inst_issue_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = IBUF_DATA_W,
  parameter int DEPTH      = 8,
  parameter int IN_W       = 2,
  parameter int OUT_W      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic                        hold_i,
  input  logic [IN_W-1:0]             in_valid_i,
  input  logic [IN_W*DATA_WIDTH-1:0]  in_data_i,
  output logic                        in_ready_o,
  output logic [OUT_W-1:0]            out_valid_o,
  output logic [OUT_W*DATA_WIDTH-1:0] out_data_o,
  input  logic [OUT_W-1:0]            issue_i,
  output logic [$clog2(DEPTH):0]      count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [CNT_W-1:0]       r_count;

  logic                   w_room;
  logic                   w_in_ready;
  logic                   w_wr_en;
  logic [CNT_W-1:0]       w_wr_num;
  logic [CNT_W-1:0]       w_iss_num;
  logic [OUT_W-1:0]       w_iss_mask;
  logic [IN_W-1:0]        w_we;
  logic [IN_W*PTR_W-1:0]  w_waddr;
  logic [OUT_W*PTR_W-1:0] w_raddr;

  // Ready looks only at registered occupancy, so same-cycle issues never
  // feed back into the producer handshake.
  assign w_room     = (CNT_W'(DEPTH) - r_count) >= CNT_W'(IN_W);
  assign w_in_ready = !rst && !hold_i && w_room;
  assign in_ready_o = w_in_ready;

  // Flush wins over any write presented in the same cycle.
  assign w_wr_en    = w_in_ready && !flush_i;
  assign w_wr_num   = w_wr_en ? CNT_W'(lead_ones(LO_MAX'(in_valid_i), IN_W)) : '0;

  // Only lanes that are actually valid can be retired.
  assign w_iss_mask = issue_i & out_valid_o;
  assign w_iss_num  = CNT_W'(lead_ones(LO_MAX'(w_iss_mask), OUT_W));

  genvar gk;
  generate
    for (gk = 0; gk < IN_W; gk++) begin : g_wr
      assign w_we[gk]                     = w_wr_en && (CNT_W'(gk) < w_wr_num);
      assign w_waddr[gk*PTR_W +: PTR_W]   = r_tail + PTR_W'(gk);
    end
    for (gk = 0; gk < OUT_W; gk++) begin : g_win
      assign w_raddr[gk*PTR_W +: PTR_W]   = r_head + PTR_W'(gk);
      assign out_valid_o[gk]              = CNT_W'(gk) < r_count;
    end
  endgenerate

  ibuf_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IN_W       (IN_W),
    .OUT_W      (OUT_W),
    .PTR_W      (PTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (in_data_i),
    .i_raddr (w_raddr),
    .o_rdata (out_data_o)
  );

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_iss_num);
      r_tail  <= r_tail + PTR_W'(w_wr_num);
      r_count <= r_count + w_wr_num - w_iss_num;
    end
  end

  assign count_o = r_count;

`ifndef SYNTHESIS
  logic [IN_W-1:0]  w_inv_p1;
  logic [OUT_W-1:0] w_iss_p1;
  assign w_inv_p1 = in_valid_i + IN_W'(1);
  assign w_iss_p1 = w_iss_mask + OUT_W'(1);

  // Protocol and occupancy sanity checks (a set bit above a clear bit is
  // detected by v & (v+1) being non-zero).
  always @(posedge clk) begin
    if (!rst) begin
      assert ((in_valid_i & w_inv_p1) == '0)
        else $error("ibuf: in_valid_i is not prefix-contiguous");
      assert ((w_iss_mask & w_iss_p1) == '0)
        else $warning("ibuf: issue_i has bits past its first zero; they are ignored");
      assert (!(in_valid_i != '0 && !w_in_ready && !flush_i))
        else $error("ibuf: write presented while in_ready_o is low");
      assert (r_count <= CNT_W'(DEPTH))
        else $error("ibuf: occupancy exceeds DEPTH");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_issue_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_issue_buffer
//  Purpose  : Self-checking bench for inst_issue_buffer against a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_issue_buffer;

  localparam int DW    = 64;
  localparam int DEPTH = 8;
  localparam int IN_W  = 2;
  localparam int OUT_W = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush_i = 1'b0;
  logic           hold_i = 1'b0;
  logic [1:0]     in_valid_i = '0;
  logic [127:0]   in_data_i = '0;
  logic           in_ready_o;
  logic [1:0]     out_valid_o;
  logic [127:0]   out_data_o;
  logic [1:0]     issue_i = '0;
  logic [3:0]     count_o;

  logic [63:0]    q[$];
  int             n_checks = 0;
  int             n_pass   = 0;

  always #5 clk = ~clk;

  inst_issue_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .hold_i     (hold_i),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .in_ready_o (in_ready_o),
    .out_valid_o(out_valid_o),
    .out_data_o (out_data_o),
    .issue_i    (issue_i),
    .count_o    (count_o)
  );

  function automatic int lo2(input logic [1:0] v);
    if (!v[0]) return 0;
    return v[1] ? 2 : 1;
  endfunction

  // Reference model: a FIFO of packets; advance it by one clock from the
  // current inputs, then wait for the edge.
  task automatic tick();
    bit         rdy;
    int         nw, ni;
    logic [1:0] vm;
    rdy = !hold_i && ((DEPTH - q.size()) >= IN_W);
    vm  = {q.size() > 1, q.size() > 0};
    nw  = (rdy && !flush_i) ? lo2(in_valid_i) : 0;
    ni  = lo2(issue_i & vm);
    if (flush_i) q.delete();
    else begin
      for (int i = 0; i < ni; i++) void'(q.pop_front());
      for (int k = 0; k < nw; k++) q.push_back(in_data_i[k*64 +: 64]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush_i = 0; hold_i = 0; in_valid_i = '0; issue_i = '0;
  endtask

  task automatic wr2(input logic [63:0] a, input logic [63:0] b);
    in_valid_i = 2'b11; in_data_i = {b, a}; tick(); in_valid_i = '0;
  endtask

  task automatic wr1(input logic [63:0] a);
    in_valid_i = 2'b01; in_data_i = {64'h0, a}; tick(); in_valid_i = '0;
  endtask

  task automatic do_flush();
    flush_i = 1; tick(); flush_i = 0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (count_o !== 4'd0) $display("FAIL reset_count got %0d exp 0", count_o); else n_pass++;
    n_checks++; if (out_valid_o !== 2'b00) $display("FAIL reset_valid got %b exp 00", out_valid_o); else n_pass++;
    n_checks++; if (in_ready_o !== 1'b0) $display("FAIL reset_ready got %b exp 0", in_ready_o); else n_pass++;
    @(negedge clk); rst = 0; #1;
    n_checks++; if (in_ready_o !== 1'b1) $display("FAIL release_ready got %b exp 1", in_ready_o); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_write_visible();
    wr2(64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B);
    n_checks++; if (out_valid_o !== 2'b11) $display("FAIL t1_valid got %b exp 11", out_valid_o); else n_pass++;
    n_checks++; if (out_data_o !== {64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A})
      $display("FAIL t1_data got %h exp B,A", out_data_o); else n_pass++;
    n_checks++; if (count_o !== 4'd2) $display("FAIL t1_count got %0d exp 2", count_o); else n_pass++;
    do_flush();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 3; i++) wr2(64'(10 + 2*i), 64'(11 + 2*i));
    n_checks++; if (count_o !== 4'd6) $display("FAIL t2_count6 got %0d exp 6", count_o); else n_pass++;
    n_checks++; if (in_ready_o !== 1'b1) $display("FAIL t2_ready6 got %b exp 1", in_ready_o); else n_pass++;
    wr2(64'd16, 64'd17);
    n_checks++; if (count_o !== 4'd8) $display("FAIL t2_count8 got %0d exp 8", count_o); else n_pass++;
    n_checks++; if (in_ready_o !== 1'b0) $display("FAIL t2_ready8 got %b exp 0", in_ready_o); else n_pass++;
    issue_i = 2'b11; tick(); issue_i = '0;
    n_checks++; if (count_o !== 4'd6) $display("FAIL t2_count_iss got %0d exp 6", count_o); else n_pass++;
    n_checks++; if (in_ready_o !== 1'b1) $display("FAIL t2_ready_iss got %b exp 1", in_ready_o); else n_pass++;
    do_flush();
  endtask

  // Offset by one dummy entry so G,H land on slots 7 and 0.
  task automatic test_wrap();
    logic [63:0] exp_seq [8];
    for (int i = 0; i < 8; i++) exp_seq[i] = 64'hC0DE_0000_0000_0000 + 64'(i);
    wr1(64'hDEAD);
    wr2(exp_seq[0], exp_seq[1]);
    wr2(exp_seq[2], exp_seq[3]);
    wr2(exp_seq[4], exp_seq[5]);
    issue_i = 2'b01; tick(); issue_i = '0;
    wr2(exp_seq[6], exp_seq[7]);
    n_checks++; if (count_o !== 4'd8) $display("FAIL t3_count got %0d exp 8", count_o); else n_pass++;
    for (int c = 0; c < 4; c++) begin
      n_checks++; if (out_data_o[63:0] !== exp_seq[2*c])
        $display("FAIL t3_lane0_%0d got %h exp %h", c, out_data_o[63:0], exp_seq[2*c]); else n_pass++;
      n_checks++; if (out_data_o[127:64] !== exp_seq[2*c+1])
        $display("FAIL t3_lane1_%0d got %h exp %h", c, out_data_o[127:64], exp_seq[2*c+1]); else n_pass++;
      issue_i = 2'b11; tick(); issue_i = '0;
    end
    n_checks++; if (count_o !== 4'd0) $display("FAIL t3_drained got %0d exp 0", count_o); else n_pass++;
  endtask

  task automatic test_nonprefix_issue();
    wr2(64'h41, 64'h42);
    wr2(64'h43, 64'h44);
    issue_i = 2'b10; tick(); issue_i = '0;
    n_checks++; if (count_o !== 4'd4) $display("FAIL t4_count got %0d exp 4", count_o); else n_pass++;
    n_checks++; if (out_data_o[63:0] !== 64'h41) $display("FAIL t4_head got %h exp 41", out_data_o[63:0]); else n_pass++;
  endtask

  task automatic test_flush_priority();
    wr1(64'h45);
    n_checks++; if (count_o !== 4'd5) $display("FAIL t5_pre got %0d exp 5", count_o); else n_pass++;
    flush_i = 1; in_valid_i = 2'b11; in_data_i = {64'h99, 64'h98}; issue_i = 2'b11;
    tick(); idle();
    n_checks++; if (count_o !== 4'd0) $display("FAIL t5_count got %0d exp 0", count_o); else n_pass++;
    n_checks++; if (out_valid_o !== 2'b00) $display("FAIL t5_valid got %b exp 00", out_valid_o); else n_pass++;
    n_checks++; if (in_ready_o !== 1'b1) $display("FAIL t5_ready got %b exp 1", in_ready_o); else n_pass++;
  endtask

  task automatic test_hold_drain();
    wr2(64'h51, 64'h52);
    wr1(64'h53);
    hold_i = 1; issue_i = 2'b11; #1;
    n_checks++; if (in_ready_o !== 1'b0) $display("FAIL t6_ready3 got %b exp 0", in_ready_o); else n_pass++;
    tick();
    n_checks++; if (count_o !== 4'd1) $display("FAIL t6_count1 got %0d exp 1", count_o); else n_pass++;
    n_checks++; if (in_ready_o !== 1'b0) $display("FAIL t6_ready1 got %b exp 0", in_ready_o); else n_pass++;
    tick();
    n_checks++; if (count_o !== 4'd0) $display("FAIL t6_count0 got %0d exp 0", count_o); else n_pass++;
    n_checks++; if (in_ready_o !== 1'b0) $display("FAIL t6_ready0 got %b exp 0", in_ready_o); else n_pass++;
    hold_i = 0; issue_i = '0; #1;
    n_checks++; if (in_ready_o !== 1'b1) $display("FAIL t6_release got %b exp 1", in_ready_o); else n_pass++;
  endtask

  task automatic test_random();
    bit         rdy;
    logic [1:0] pre [3];
    pre[0] = 2'b00; pre[1] = 2'b01; pre[2] = 2'b11;
    for (int c = 0; c < 400; c++) begin
      hold_i     = ($urandom_range(0, 7) == 0);
      flush_i    = ($urandom_range(0, 24) == 0);
      issue_i    = pre[$urandom_range(0, 2)];
      rdy        = !hold_i && ((DEPTH - q.size()) >= IN_W);
      in_valid_i = rdy ? pre[$urandom_range(0, 2)] : 2'b00;
      in_data_i  = {$urandom, $urandom, $urandom, $urandom};
      #1;
      n_checks++; if (in_ready_o !== rdy) $display("FAIL rnd_ready c%0d got %b exp %b", c, in_ready_o, rdy); else n_pass++;
      tick();
      n_checks++; if (count_o !== 4'(q.size())) $display("FAIL rnd_count c%0d got %0d exp %0d", c, count_o, q.size()); else n_pass++;
      for (int i = 0; i < OUT_W; i++) begin
        n_checks++; if (out_valid_o[i] !== (i < q.size()))
          $display("FAIL rnd_valid c%0d l%0d got %b", c, i, out_valid_o[i]); else n_pass++;
        if (i < q.size()) begin
          n_checks++; if (out_data_o[i*64 +: 64] !== q[i])
            $display("FAIL rnd_data c%0d l%0d got %h exp %h", c, i, out_data_o[i*64 +: 64], q[i]); else n_pass++;
        end
      end
    end
    idle();
    do_flush();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) wr2(64'(100 + i), 64'(200 + i));
    n_checks++; if (count_o !== 4'd6) $display("FAIL t7_pre got %0d exp 6", count_o); else n_pass++;
    #1 rst = 1;
    #1;
    n_checks++; if (count_o !== 4'd0) $display("FAIL t7_count got %0d exp 0", count_o); else n_pass++;
    n_checks++; if (out_valid_o !== 2'b00) $display("FAIL t7_valid got %b exp 00", out_valid_o); else n_pass++;
    n_checks++; if (in_ready_o !== 1'b0) $display("FAIL t7_ready got %b exp 0", in_ready_o); else n_pass++;
    #1 rst = 0;
    q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write_visible();
    test_fill();
    test_wrap();
    test_nonprefix_issue();
    test_flush_priority();
    test_hold_drain();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
